wb_stage: RTL and testbench

- Write-back stage, directly downstream of the execute/memory stage.
- Contains the EX/M→WB pipeline register and selects the write-back data.
- Drives the register-file write port and the output port.
- Generates the operand-forwarding selects and forwarded data (i_data1_forward / i_data2_forward / i_data_wb) back to the execute/memory stage. It also counts retired instructions.

---
 rtl/wb_stage.sv | 114 +++++++++++
 tb/tb_wb_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: EX/M->WB pipeline register, write-back select, register-file
// write port, output port, operand forwarding and retired-instruction counter.
module wb_stage #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned REG_ADDR_WIDTH = 3,
    parameter int unsigned COUNT_WIDTH    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic [DATA_WIDTH-1:0]     i_ex_result,
    input  logic [DATA_WIDTH-1:0]     i_memory_data,
    input  logic [DATA_WIDTH-1:0]     i_immediate,
    input  logic [DATA_WIDTH-1:0]     i_input_port,
    input  logic [1:0]                i_wb_selector,
    input  logic                      i_write_back,
    input  logic [REG_ADDR_WIDTH-1:0] i_write_addr,
    input  logic                      i_out_port_en,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rs2,
    output logic                      o_rf_write_enable,
    output logic [REG_ADDR_WIDTH-1:0] o_rf_write_addr,
    output logic [DATA_WIDTH-1:0]     o_data_wb,
    output logic                      o_data1_forward,
    output logic                      o_data2_forward,
    output logic [DATA_WIDTH-1:0]     o_out_port,
    output logic [COUNT_WIDTH-1:0]    o_retired_count
);

    localparam int unsigned SEL_WIDTH = 2;

    logic                      wb_valid;
    logic                      wb_write_back;
    logic                      wb_out_en;
    logic [SEL_WIDTH-1:0]      wb_selector;
    logic [REG_ADDR_WIDTH-1:0] wb_write_addr;
    logic [DATA_WIDTH-1:0]     wb_ex_result;
    logic [DATA_WIDTH-1:0]     wb_memory_data;
    logic [DATA_WIDTH-1:0]     wb_immediate;
    logic [DATA_WIDTH-1:0]     wb_input_port;
    logic                      commit;
    logic                      wb_writes;

    // Pipeline register: flush beats stall beats load; bubbles never write or drive OUT.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wb_valid       <= 1'b0;
            wb_write_back  <= 1'b0;
            wb_out_en      <= 1'b0;
            wb_selector    <= '0;
            wb_write_addr  <= '0;
            wb_ex_result   <= '0;
            wb_memory_data <= '0;
            wb_immediate   <= '0;
            wb_input_port  <= '0;
        end else if (i_flush) begin
            wb_valid       <= 1'b0;
            wb_write_back  <= 1'b0;
            wb_out_en      <= 1'b0;
            wb_selector    <= '0;
            wb_write_addr  <= '0;
            wb_ex_result   <= '0;
            wb_memory_data <= '0;
            wb_immediate   <= '0;
            wb_input_port  <= '0;
        end else if (!i_stall) begin
            wb_valid       <= i_valid;
            wb_write_back  <= i_valid & i_write_back;
            wb_out_en      <= i_valid & i_out_port_en;
            wb_selector    <= i_wb_selector;
            wb_write_addr  <= i_write_addr;
            wb_ex_result   <= i_ex_result;
            wb_memory_data <= i_memory_data;
            wb_immediate   <= i_immediate;
            wb_input_port  <= i_input_port;
        end
    end

    always_comb begin
        o_data_wb = wb_ex_result;
        case (wb_selector)
            2'b00:   o_data_wb = wb_ex_result;
            2'b01:   o_data_wb = wb_memory_data;
            2'b10:   o_data_wb = wb_immediate;
            default: o_data_wb = wb_input_port;
        endcase
    end

    assign commit            = wb_valid & ~i_stall;
    assign wb_writes         = wb_valid & wb_write_back;
    assign o_rf_write_enable = wb_writes & ~i_stall;
    assign o_rf_write_addr   = wb_write_addr;

    // Forwarding ignores stall: the held WB value is still the newest copy.
    assign o_data1_forward = wb_writes & (wb_write_addr == i_ex_rs1);
    assign o_data2_forward = wb_writes & (wb_write_addr == i_ex_rs2);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_out_port      <= '0;
            o_retired_count <= '0;
        end else begin
            if (commit && wb_out_en) begin
                o_out_port <= o_data_wb;
            end
            if (commit) begin
                o_retired_count <= o_retired_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: select, forwarding, stall, flush, reset and counter wrap.
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [15:0] ex_result;
    logic [15:0] memory_data;
    logic [15:0] immediate;
    logic [15:0] input_port;
    logic [1:0]  wb_selector;
    logic        write_back;
    logic [2:0]  write_addr;
    logic        out_port_en;
    logic        stall;
    logic        flush;
    logic [2:0]  ex_rs1;
    logic [2:0]  ex_rs2;
    logic        rf_write_enable;
    logic [2:0]  rf_write_addr;
    logic [15:0] data_wb;
    logic        data1_forward;
    logic        data2_forward;
    logic [15:0] out_port;
    logic [15:0] retired_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    wb_stage dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_valid           (valid),
        .i_ex_result       (ex_result),
        .i_memory_data     (memory_data),
        .i_immediate       (immediate),
        .i_input_port      (input_port),
        .i_wb_selector     (wb_selector),
        .i_write_back      (write_back),
        .i_write_addr      (write_addr),
        .i_out_port_en     (out_port_en),
        .i_stall           (stall),
        .i_flush           (flush),
        .i_ex_rs1          (ex_rs1),
        .i_ex_rs2          (ex_rs2),
        .o_rf_write_enable (rf_write_enable),
        .o_rf_write_addr   (rf_write_addr),
        .o_data_wb         (data_wb),
        .o_data1_forward   (data1_forward),
        .o_data2_forward   (data2_forward),
        .o_out_port        (out_port),
        .o_retired_count   (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic wb,
                         input logic [2:0] addr, input logic oe, input logic [15:0] ex);
        valid       = v;
        wb_selector = sel;
        write_back  = wb;
        write_addr  = addr;
        out_port_en = oe;
        ex_result   = ex;
    endtask

    initial begin
        logic [15:0] sel_exp [4];
        sel_exp[0] = 16'h1111;
        sel_exp[1] = 16'h2222;
        sel_exp[2] = 16'h3333;
        sel_exp[3] = 16'h4444;

        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        ex_rs1 = 3'd0;
        ex_rs2 = 3'd0;
        memory_data = 16'h2222;
        immediate   = 16'h3333;
        input_port  = 16'h4444;
        drive(1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 16'h1111);
        #1;
        check("reset_we", 32'(rf_write_enable), 32'd0);
        check("reset_data", 32'(data_wb), 32'd0);
        check("reset_out", 32'(out_port), 32'd0);
        check("reset_cnt", 32'(retired_count), 32'd0);
        check("reset_fwd1", 32'(data1_forward), 32'd0);
        repeat (2) tick();
        reset = 1'b0;

        // Four selects, one per instruction, writing R1..R4
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 1'b1, 3'(k + 1), 1'b0, 16'h1111);
            tick();
            check("sel_data", 32'(data_wb), 32'(sel_exp[k]));
            check("sel_we", 32'(rf_write_enable), 32'd1);
            check("sel_addr", 32'(rf_write_addr), 32'(k + 1));
            check("sel_cnt", 32'(retired_count), 32'(exp_cnt));
            exp_cnt++;
        end
        drive(1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 16'h0000);
        tick();
        check("sel_cnt_final", 32'(retired_count), 32'd4);
        check("bubble_we", 32'(rf_write_enable), 32'd0);

        // Forwarding from a write to R5
        drive(1'b1, 2'b00, 1'b1, 3'd5, 1'b0, 16'h5555);
        tick();
        ex_rs1 = 3'd5;
        ex_rs2 = 3'd5;
        #1;
        check("fwd_both1", 32'(data1_forward), 32'd1);
        check("fwd_both2", 32'(data2_forward), 32'd1);
        check("fwd_data", 32'(data_wb), 32'h5555);
        ex_rs2 = 3'd3;
        #1;
        check("fwd_rs2_miss", 32'(data2_forward), 32'd0);
        check("fwd_rs1_hit", 32'(data1_forward), 32'd1);
        drive(1'b1, 2'b00, 1'b0, 3'd5, 1'b0, 16'h6666);
        tick();
        exp_cnt++;
        ex_rs2 = 3'd5;
        #1;
        check("fwd_nowb1", 32'(data1_forward), 32'd0);
        check("fwd_nowb2", 32'(data2_forward), 32'd0);
        check("nowb_we", 32'(rf_write_enable), 32'd0);

        // Stall: OUT of 0xBEEF writing R6 held for three cycles
        drive(1'b1, 2'b00, 1'b1, 3'd6, 1'b1, 16'hBEEF);
        tick();
        exp_cnt++;
        check("stall_pre_out", 32'(out_port), 32'd0);
        check("stall_pre_cnt", 32'(retired_count), 32'(exp_cnt));
        stall = 1'b1;
        ex_rs1 = 3'd6;
        drive(1'b1, 2'b00, 1'b0, 3'd1, 1'b1, 16'h1234);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_out", 32'(out_port), 32'd0);
            check("stall_cnt", 32'(retired_count), 32'(exp_cnt));
            check("stall_we", 32'(rf_write_enable), 32'd0);
            check("stall_data", 32'(data_wb), 32'hBEEF);
            check("stall_fwd", 32'(data1_forward), 32'd1);
        end
        stall = 1'b0;
        #1;
        check("release_we", 32'(rf_write_enable), 32'd1);
        check("release_addr", 32'(rf_write_addr), 32'd6);
        tick();
        exp_cnt++;
        check("release_out", 32'(out_port), 32'hBEEF);
        check("release_cnt", 32'(retired_count), 32'(exp_cnt));
        check("release_next", 32'(data_wb), 32'h1234);
        check("release_once", 32'(rf_write_enable), 32'd0);
        drive(1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 16'h0000);
        tick();
        exp_cnt++;
        check("out2", 32'(out_port), 32'h1234);

        // Flush with a valid write arriving
        flush = 1'b1;
        drive(1'b1, 2'b00, 1'b1, 3'd7, 1'b1, 16'h7777);
        tick();
        flush = 1'b0;
        check("flush_we", 32'(rf_write_enable), 32'd0);
        check("flush_cnt", 32'(retired_count), 32'(exp_cnt));
        check("flush_data", 32'(data_wb), 32'd0);
        drive(1'b0, 2'b00, 1'b1, 3'd7, 1'b1, 16'h7777);
        ex_rs1 = 3'd7;
        tick();
        check("bubble_wb_we", 32'(rf_write_enable), 32'd0);
        check("bubble_wb_fwd", 32'(data1_forward), 32'd0);
        check("bubble_wb_cnt", 32'(retired_count), 32'(exp_cnt));
        check("bubble_wb_out", 32'(out_port), 32'h1234);

        // Flush alone: instruction in WB still commits
        drive(1'b1, 2'b00, 1'b1, 3'd2, 1'b0, 16'h0042);
        tick();
        flush = 1'b1;
        drive(1'b1, 2'b00, 1'b1, 3'd3, 1'b0, 16'h0043);
        tick();
        exp_cnt++;
        flush = 1'b0;
        check("flush_commit_cnt", 32'(retired_count), 32'(exp_cnt));
        check("flush_commit_we", 32'(rf_write_enable), 32'd0);

        // Flush together with stall: WB instruction dropped, not counted
        drive(1'b1, 2'b00, 1'b1, 3'd4, 1'b0, 16'h0044);
        tick();
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 16'h0000);
        tick();
        check("flush_stall_cnt", 32'(retired_count), 32'(exp_cnt));

        // Asynchronous reset mid-cycle with a valid write and OUT in WB
        drive(1'b1, 2'b00, 1'b1, 3'd1, 1'b1, 16'hAAAA);
        tick();
        check("pre_reset_we", 32'(rf_write_enable), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_we", 32'(rf_write_enable), 32'd0);
        check("async_out", 32'(out_port), 32'd0);
        check("async_cnt", 32'(retired_count), 32'd0);
        check("async_data", 32'(data_wb), 32'd0);
        tick();
        reset = 1'b0;
        exp_cnt = 0;

        // Counter wrap through continuous retirements
        drive(1'b1, 2'b00, 1'b0, 3'd0, 1'b0, 16'h0001);
        repeat (65536) tick();
        check("cnt_max", 32'(retired_count), 32'h0000FFFF);
        tick();
        check("cnt_wrap", 32'(retired_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
